// File: rtl/aes_decrypt_iterative.sv
// Iterative AES-128 decryption core. One ciphertext block is taken in IDLE,
// one inverse round is applied per clock, and the plaintext is held in DONE
// until the downstream side accepts it. Round keys are fetched from an
// external key-schedule store by index, highest index first.
module aes_decrypt_iterative #(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    output logic [KIDX_W-1:0] key_idx,
    input  logic [127:0]      round_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    fsm_t              fsm_reg, fsm_next;
    logic [127:0]      blk_reg, blk_next;
    logic [KIDX_W-1:0] rnd_reg, rnd_next;
    logic [127:0]      out_data_reg, out_data_next;

    // Shared round datapath: shifted -> subbed -> keyed -> mixed.
    logic [127:0]      shifted;
    logic [127:0]      subbed;
    logic [127:0]      keyed;
    logic [127:0]      mixed;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = x;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    // Inverse S-box: undo the affine transform, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    genvar gi;

    // InvShiftRows + InvSubBytes: byte (row r, col c) comes from col (c - r) mod 4.
    generate
        for (gi = 0; gi < 16; gi++) begin : g_inv_shift_sub
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
            assign shifted[127-8*gi -: 8] = blk_reg[127-8*SRC -: 8];
            assign subbed[127-8*gi -: 8]  = inv_sbox(shifted[127-8*gi -: 8]);
        end
    endgenerate

    // AddRoundKey with the key selected by key_idx this cycle.
    assign keyed = subbed ^ round_key;

    // InvMixColumns applied independently to each of the four columns.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_inv_mix_columns
            logic [7:0] a0, a1, a2, a3;
            assign a0 = keyed[127-32*gi -: 8];
            assign a1 = keyed[119-32*gi -: 8];
            assign a2 = keyed[111-32*gi -: 8];
            assign a3 = keyed[103-32*gi -: 8];
            assign mixed[127-32*gi -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                                         ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            assign mixed[119-32*gi -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                                         ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            assign mixed[111-32*gi -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                                         ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            assign mixed[103-32*gi -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                                         ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
    endgenerate

    // Next-state and output decode; outputs depend only on registered state.
    always_comb begin
        fsm_next      = fsm_reg;
        blk_next      = blk_reg;
        rnd_next      = rnd_reg;
        out_data_next = out_data_reg;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b1;
        key_idx       = KIDX_W'(NR);
        case (fsm_reg)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    blk_next = in_data ^ round_key;
                    rnd_next = KIDX_W'(NR - 1);
                    fsm_next = ROUND;
                end
            end
            ROUND: begin
                key_idx  = rnd_reg;
                blk_next = mixed;
                if (rnd_reg == KIDX_W'(1)) begin
                    fsm_next = FINAL;
                end else begin
                    rnd_next = rnd_reg - KIDX_W'(1);
                end
            end
            FINAL: begin
                key_idx       = '0;
                out_data_next = keyed;
                fsm_next      = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_next = IDLE;
                end
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    // State registers; reset discards any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg      <= IDLE;
            blk_reg      <= '0;
            rnd_reg      <= '0;
            out_data_reg <= '0;
        end else begin
            fsm_reg      <= fsm_next;
            blk_reg      <= blk_next;
            rnd_reg      <= rnd_next;
            out_data_reg <= out_data_next;
        end
    end

    assign out_data = out_data_reg;

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Bench for the iterative AES-128 decryptor: directed FIPS-197 vectors,
// backpressure, back-to-back, mid-round reset and randomized traffic, all
// checked every cycle against a cycle-timeline model built on a textbook
// InvCipher with its own S-box tables and key expansion.
module tb_aes_decrypt_iterative;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   key_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int n_checks = 0;
    int n_err    = 0;
    int n_txn    = 0;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk_tbl [11];
    logic [127:0] got_q [$];

    aes_decrypt_iterative #(.NR(10), .KIDX_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_idx   (key_idx),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Key-schedule store: combinational lookup by key_idx.
    always_comb begin
        round_key = '0;
        for (int r = 0; r <= 10; r++) begin
            if (key_idx == 4'(r)) round_key = rk_tbl[r];
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] t;
        r = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ t;
            t = xt(t);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Forward S-box by brute-force inverse + affine map; inverse table by lookup.
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    // AES-128 key expansion into the round-key store.
    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]}
                    ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk_tbl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Textbook InvCipher on a byte array (column-major state).
    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int b = 0; b < 16; b++) s[b] = ct[127-8*b -: 8] ^ rk_tbl[10][127-8*b -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = s[4*((c - row + 4) % 4) + row];
            for (int b = 0; b < 16; b++) t[b] = isbox[t[b]] ^ rk_tbl[r][127-8*b -: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                    t[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                    t[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                    t[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
                end
            end
            s = t;
        end
        for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
        return res;
    endfunction

    // Timeline model: m_cnt = 0 idle, 1..10 cycles after acceptance, 11 = result held.
    int           m_cnt;
    logic [127:0] m_pend;
    logic [127:0] m_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_out <= '0;
        end else if (m_cnt == 0) begin
            if (in_valid) begin
                m_pend <= ref_decrypt(in_data);
                m_cnt  <= 1;
            end
        end else if (m_cnt < 11) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 10) m_out <= m_pend;
        end else if (out_ready) begin
            m_cnt <= 0;
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        int ek;
        if (rst_n) begin
            ek = (m_cnt == 0 || m_cnt >= 11) ? 10 : 10 - m_cnt;
            chk("in_ready",  128'(in_ready),  128'(m_cnt == 0));
            chk("out_valid", 128'(out_valid), 128'(m_cnt == 11));
            chk("busy",      128'(busy),      128'(m_cnt != 0));
            chk("key_idx",   128'(key_idx),   128'(ek));
            chk("out_data",  out_data,        m_out);
            if (m_cnt == 11 && out_ready) begin
                got_q.push_back(out_data);
                n_txn++;
                $display("txn %0d plaintext=%h at %0t", n_txn, out_data, $time);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},  128'(in_ready),  128'(1));
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_busy"},      128'(busy),      128'(0));
        chk({tag, "_key_idx"},   128'(key_idx),   128'(10));
        chk({tag, "_out_data"},  out_data,        128'(0));
    endtask

    // Steps until out_valid; returns the number of edges taken, or -1 on timeout.
    task automatic wait_out_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 60) begin
            step();
            edges++;
        end
        if (!out_valid) edges = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc;
        int gap;
        int edges;
        bit switched;
        bit will_acc;
        bit hs;
        bit done;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        build_tables();
        set_key(C1_KEY);
        repeat (2) step();
        check_reset_values("reset");
        rst_n = 1'b1;
        step();

        // Pin the reference model to published values.
        chk("c1_rk10", rk_tbl[10], C1_RK10);
        chk("c1_model_pt", ref_decrypt(C1_CT), C1_PT);
        set_key(B_KEY);
        chk("b_rk10", rk_tbl[10], B_RK10);
        chk("b_model_pt", ref_decrypt(B_CT), B_PT);

        // C.1 vector: latency, single-cycle out_valid, garbage in_valid while busy.
        set_key(C1_KEY);
        out_ready = 1'b1;
        in_data   = C1_CT;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            in_valid = (lat == 3);
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            step();
            lat++;
        end
        in_valid = 1'b0;
        chk("c1_latency", 128'(lat), 128'(10));
        chk("c1_out_data", out_data, C1_PT);
        step();
        chk("c1_valid_one_cycle", 128'(out_valid), 128'(0));
        chk("c1_ready_after", 128'(in_ready), 128'(1));

        // App. B vector: key_idx sequence, then 20 cycles of backpressure.
        set_key(B_KEY);
        out_ready = 1'b0;
        in_data   = B_CT;
        in_valid  = 1'b1;
        chk("b_kidx_idle", 128'(key_idx), 128'(10));
        step();
        in_valid = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            chk("b_kidx_seq", 128'(key_idx), 128'((e <= 9) ? 9 - e : 10));
            if (e < 10) step();
        end
        chk("b_out_valid", 128'(out_valid), 128'(1));
        chk("b_out_data", out_data, B_PT);
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            step();
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_out_data", out_data, B_PT);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 128'(out_valid), 128'(0));
        chk("bp_release_ready", 128'(in_ready), 128'(1));

        // Back-to-back: both vectors offered continuously.
        got_q.delete();
        set_key(C1_KEY);
        in_valid = 1'b1;
        in_data  = C1_CT;
        acc = 0;
        gap = 0;
        switched = 1'b0;
        for (int k = 0; k < 60 && acc < 2; k++) begin
            will_acc = in_ready && in_valid;
            if (acc == 1 && !in_ready) gap++;
            step();
            if (will_acc) begin
                acc++;
                if (acc == 1) in_data = B_CT;
                else in_valid = 1'b0;
            end
            if (acc == 1 && out_valid && !switched) begin
                set_key(B_KEY);
                switched = 1'b1;
            end
        end
        in_valid = 1'b0;
        chk("b2b_accepts", 128'(acc), 128'(2));
        chk("b2b_busy_gap", 128'(gap), 128'(11));
        for (int k = 0; k < 40 && got_q.size() < 2; k++) step();
        chk("b2b_count", 128'(got_q.size()), 128'(2));
        if (got_q.size() >= 2) begin
            chk("b2b_first", got_q[0], C1_PT);
            chk("b2b_second", got_q[1], B_PT);
        end
        step();

        // Reset mid-ROUND, then a clean App. B decryption.
        set_key(B_KEY);
        out_ready = 1'b1;
        in_data   = B_CT;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_reset_no_valid", 128'(out_valid), 128'(0));
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out_valid(edges);
        chk("post_reset_latency", 128'(edges), 128'(10));
        chk("post_reset_pt", out_data, B_PT);
        step();

        // Randomized traffic with random keys and handshake timing.
        for (int t = 0; t < 25; t++) begin
            in_valid = 1'b0;
            set_key({$urandom, $urandom, $urandom, $urandom});
            in_data = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 2)) step();
            in_valid = 1'b1;
            step();
            done = 1'b0;
            for (int k = 0; k < 300 && !done; k++) begin
                in_valid  = ($urandom_range(0, 3) == 0);
                in_data   = {$urandom, $urandom, $urandom, $urandom};
                out_ready = ($urandom_range(0, 1) == 1);
                hs = out_valid && out_ready;
                step();
                if (hs) done = 1'b1;
            end
            in_valid = 1'b0;
            chk("rand_done", 128'(done), 128'(1));
        end
        out_ready = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
